// File: rtl/sensor_power_down_pkg.sv
// Shared types and defaults for the sensor power sequencers.
// Both the power-up and power-down blocks use these.
package sensor_pwr_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RST,
    CLK,
    SLVS,
    VDD,
    VDDIO,
    VAA,
    PLL,
    OFF
  } pwr_state_t;

  localparam int DEFAULT_RST_CYCLES  = 500;
  localparam int DEFAULT_CLK_CYCLES  = 500;
  localparam int DEFAULT_RAIL_CYCLES = 500;

  function automatic logic is_sequencing(pwr_state_t s);
    return (s != IDLE) && (s != OFF);
  endfunction

endpackage

// File: rtl/sensor_power_down_if.sv
// Control and permit bundle between the power-down sequencer and its host.
interface sensor_power_down_if;

  logic start;
  logic kill;
  logic clear;
  logic done;
  logic busy;
  logic off;
  logic keep_reset_bar;
  logic keep_extclk;
  logic keep_vdd_slvs;
  logic keep_vdd;
  logic keep_vdd_io;
  logic keep_vaa;
  logic keep_vdd_pll;

  modport master (
    output start, kill, clear,
    input  done, busy, off,
    input  keep_reset_bar, keep_extclk, keep_vdd_slvs, keep_vdd,
    input  keep_vdd_io, keep_vaa, keep_vdd_pll
  );

  modport slave (
    input  start, kill, clear,
    output done, busy, off,
    output keep_reset_bar, keep_extclk, keep_vdd_slvs, keep_vdd,
    output keep_vdd_io, keep_vaa, keep_vdd_pll
  );

endinterface

// File: rtl/sensor_power_down_dwell_timer.sv
// Dwell counter: restarts from zero on clear and flags the last cycle of an N-cycle dwell.
module sensor_dwell_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [CNT_W-1:0] n,
  output logic             expire
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign expire = (count == (n - CNT_W'(1)));

endmodule

// File: rtl/sensor_power_down.sv
// Sensor power-down sequencer: removes reset, extclk and rails in reverse power-up order,
// with an immediate kill path to OFF.
module sensor_power_down
  import sensor_pwr_pkg::*;
#(
  parameter int RST_CYCLES  = DEFAULT_RST_CYCLES,
  parameter int CLK_CYCLES  = DEFAULT_CLK_CYCLES,
  parameter int RAIL_CYCLES = DEFAULT_RAIL_CYCLES,
  parameter int CNT_W       = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  sensor_power_down_if.slave  pd
);

  pwr_state_t       state;
  pwr_state_t       state_next;
  logic [CNT_W-1:0] dwell;
  logic             expire;
  logic             timer_clear;
  logic             done_q;

  always_comb begin
    dwell = CNT_W'(RAIL_CYCLES);
    case (state)
      RST:     dwell = CNT_W'(RST_CYCLES);
      CLK:     dwell = CNT_W'(CLK_CYCLES);
      default: dwell = CNT_W'(RAIL_CYCLES);
    endcase
  end

  // Restart the dwell on every state change; idle/off states hold it at zero.
  assign timer_clear = (state_next != state) || !is_sequencing(state);

  sensor_dwell_timer #(.CNT_W(CNT_W)) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .n       (dwell),
    .expire  (expire)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= (state_next == OFF) && (state != OFF);
    end
  end

  always_comb begin
    state_next = state;
    if (state == OFF) begin
      if (pd.clear) state_next = IDLE;
    end else if (pd.kill) begin
      state_next = OFF;
    end else begin
      case (state)
        IDLE:    if (pd.start) state_next = RST;
        RST:     if (expire)   state_next = CLK;
        CLK:     if (expire)   state_next = SLVS;
        SLVS:    if (expire)   state_next = VDD;
        VDD:     if (expire)   state_next = VDDIO;
        VDDIO:   if (expire)   state_next = VAA;
        VAA:     if (expire)   state_next = PLL;
        PLL:     if (expire)   state_next = OFF;
        default: state_next = IDLE;
      endcase
    end
  end

  // OFF encodes highest, so each ordered compare already forces its permit low in OFF.
  assign pd.keep_reset_bar = (state == IDLE);
  assign pd.keep_extclk    = (state <= RST);
  assign pd.keep_vdd_slvs  = (state <= CLK);
  assign pd.keep_vdd       = (state <= SLVS);
  assign pd.keep_vdd_io    = (state <= VDD);
  assign pd.keep_vaa       = (state <= VDDIO);
  assign pd.keep_vdd_pll   = (state <= VAA);

  assign pd.busy = is_sequencing(state);
  assign pd.off  = (state == OFF);
  assign pd.done = done_q;

endmodule

// File: tb/tb_sensor_power_down.sv
// Bench for sensor_power_down: two instances (4/4/4 and 1/1/1 dwells) driven in lockstep
// and compared each cycle against an elapsed-time model of the shutdown order.
module tb_sensor_power_down;

  logic clock;
  logic reset_n;
  logic start;
  logic kill;
  logic clear;

  int total = 0;
  int bad   = 0;

  sensor_power_down_if if_a ();
  sensor_power_down_if if_b ();

  assign if_a.start = start;
  assign if_a.kill  = kill;
  assign if_a.clear = clear;
  assign if_b.start = start;
  assign if_b.kill  = kill;
  assign if_b.clear = clear;

  sensor_power_down #(
    .RST_CYCLES (4),
    .CLK_CYCLES (4),
    .RAIL_CYCLES(4),
    .CNT_W      (32)
  ) dut_a (
    .clock  (clock),
    .reset_n(reset_n),
    .pd     (if_a.slave)
  );

  sensor_power_down #(
    .RST_CYCLES (1),
    .CLK_CYCLES (1),
    .RAIL_CYCLES(1),
    .CNT_W      (8)
  ) dut_b (
    .clock  (clock),
    .reset_n(reset_n),
    .pd     (if_b.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [6:0] keep_obs [2];
  logic [2:0] stat_obs [2];

  assign keep_obs[0] = {if_a.keep_reset_bar, if_a.keep_extclk, if_a.keep_vdd_slvs, if_a.keep_vdd,
                        if_a.keep_vdd_io, if_a.keep_vaa, if_a.keep_vdd_pll};
  assign keep_obs[1] = {if_b.keep_reset_bar, if_b.keep_extclk, if_b.keep_vdd_slvs, if_b.keep_vdd,
                        if_b.keep_vdd_io, if_b.keep_vaa, if_b.keep_vdd_pll};
  assign stat_obs[0] = {if_a.busy, if_a.off, if_a.done};
  assign stat_obs[1] = {if_b.busy, if_b.off, if_b.done};

  // Model: mode 0 = waiting, 1 = shutting down (t cycles since the start edge), 2 = shut off.
  int p_rst  [2] = '{4, 1};
  int p_clk  [2] = '{4, 1};
  int p_rail [2] = '{4, 1};
  int m_mode [2];
  int m_t    [2];
  bit m_done [2];

  function automatic int seq_len(int i);
    return p_rst[i] + p_clk[i] + 5 * p_rail[i];
  endfunction

  function automatic logic [6:0] exp_keep(int i);
    int b;
    int l;
    int t;
    if (m_mode[i] == 0) return 7'h7f;
    if (m_mode[i] == 2) return 7'h00;
    t = m_t[i];
    b = p_rst[i] + p_clk[i];
    l = p_rail[i];
    return {1'b0, t < p_rst[i], t < b, t < b + l, t < b + 2 * l, t < b + 3 * l, t < b + 4 * l};
  endfunction

  function automatic logic [2:0] exp_stat(int i);
    return {m_mode[i] == 1, m_mode[i] == 2, m_done[i]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0;
      m_t[i]    = 0;
      m_done[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 1'b0;
      if (!reset_n) begin
        m_mode[i] = 0;
      end else if (m_mode[i] == 2) begin
        if (clear) m_mode[i] = 0;
      end else if (kill) begin
        m_mode[i] = 2;
        m_done[i] = 1'b1;
      end else if (m_mode[i] == 0) begin
        if (start) begin
          m_mode[i] = 1;
          m_t[i]    = 0;
        end
      end else begin
        m_t[i]++;
        if (m_t[i] >= seq_len(i)) begin
          m_mode[i] = 2;
          m_done[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare(input string tag, input int i, input logic [6:0] obs, input logic [6:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s dut%0d at %0t: got %b want %b", tag, i, $time, obs, exp);
    end
  endtask

  task automatic check_output();
    for (int i = 0; i < 2; i++) begin
      compare("keep", i, keep_obs[i], exp_keep(i));
      compare("busy/off/done", i, {4'b0, stat_obs[i]}, {4'b0, exp_stat(i)});
    end
  endtask

  task automatic apply_stimulus(input bit s, input bit k, input bit c, input int cycles);
    start = s;
    kill  = k;
    clear = c;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clock);
      model_step();
      #1;
      check_output();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    kill    = 1'b0;
    clear   = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_output();
    @(negedge clock);
    reset_n = 1'b1;

    apply_stimulus(0, 0, 0, 2);

    // Full sequence: 28 cycles for dut_a, 7 for dut_b, then both sit in OFF.
    apply_stimulus(1, 0, 0, 1);
    apply_stimulus(0, 0, 0, 30);
    apply_stimulus(0, 0, 1, 1);
    apply_stimulus(0, 0, 0, 1);

    // Kill two cycles into dut_a's VDD dwell.
    apply_stimulus(1, 0, 0, 1);
    apply_stimulus(0, 0, 0, 14);
    apply_stimulus(0, 1, 0, 1);
    apply_stimulus(0, 0, 0, 3);

    // clear with kill in OFF re-arms without a done pulse.
    apply_stimulus(0, 1, 1, 1);
    apply_stimulus(0, 0, 0, 2);

    // start with kill in IDLE goes straight to OFF.
    apply_stimulus(1, 1, 0, 1);
    apply_stimulus(0, 0, 0, 3);
    apply_stimulus(0, 1, 1, 1);

    apply_stimulus(1, 0, 0, 1);
    apply_stimulus(0, 0, 0, 30);
    apply_stimulus(0, 0, 1, 1);

    // Asynchronous reset while dut_a is in its CLK dwell.
    apply_stimulus(1, 0, 0, 1);
    apply_stimulus(0, 0, 0, 5);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_output();
    apply_stimulus(0, 0, 0, 2);
    @(negedge clock);
    reset_n = 1'b1;
    apply_stimulus(0, 0, 0, 1);
    apply_stimulus(1, 0, 0, 1);
    apply_stimulus(0, 0, 0, 30);

    // Random control traffic, including occasional resets.
    for (int n = 0; n < 400; n++) begin
      reset_n = ($urandom_range(0, 59) != 0);
      apply_stimulus($urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0,
                     $urandom_range(0, 5) == 0, 1);
    end
    reset_n = 1'b1;
    apply_stimulus(0, 0, 0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
